dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Turns the registered memory controls, address and store data into a handshaked word-addressed data-memory request. Formats load data back into the pipeline.
- Raises a memory-side stall while an access is outstanding and flags address-alignment exceptions.
- Sits between the EX/MEM register and the data memory/cache port; result feeds the MEM/WB register.

Parameters:
- ADDR_W, 30, width of the word address to data memory (byte address bits 31:2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- M_MemRead  in  1  load in MEM stage
- M_MemWrite  in  1  store in MEM stage
- M_MemByte  in  1  byte access
- M_MemHalf  in  1  halfword access (word when neither byte nor half is set)
- M_MemSignExtend  in  1  sign-extend sub-word loads
- M_ReverseEndian  in  1  little-endian lane mapping
- M_LLSC  in  1  load-linked / store-conditional
- M_Kill  in  1  MEM instruction squashed by an exception; issue no new access
- M_StallExt  in  1  MEM stage held by another source
- M_ALU_Result  in  32  byte address
- M_ReadData2  in  32  store data
- DataMem_Ready  in  1  memory completes the current request this cycle
- DataMem_In  in  32  memory read word
- DataMem_Address  out  ADDR_W  word address
- DataMem_Read  out  1  read request
- DataMem_Write  out  4  byte write enables; bit 3 = bits 31:24
- DataMem_Out  out  32  lane-aligned store data
- M_ReadData  out  32  formatted load result
- M_Stall  out  1  memory access outstanding
- EXC_AdEL  out  1  misaligned load
- EXC_AdES  out  1  misaligned store

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE and the capture register clears to 0.
  - All outputs go to 0 while reset is asserted.
  - Reset mid-access drops the request in the same cycle; no completion is recorded.
- Alignment:
  - Word access needs addr[1:0]=0; half needs addr[0]=0.
  - On a misaligned access, assert EXC_AdEL (read) or EXC_AdES (write) combinationally.
  - A misaligned access issues no request and raises no stall.
- Lane offset: o = addr[1:0] XOR {2{M_ReverseEndian}}.
- Store enables and data:
  - Byte: enable bit (3-o); data {4{rd2[7:0]}}.
  - Half: o=0 gives 4'b1100, o=2 gives 4'b0011; data {2{rd2[15:0]}}.
  - Word: 4'b1111; data rd2.
- Load result:
  - Select the byte/half at lane o; sign-extend if M_MemSignExtend, else zero-extend.
  - Word loads pass through unchanged.
- Valid op: (Read|Write), aligned, and not killed in IDLE.
- States:
  - IDLE
    - Valid op drives the request combinationally.
    - DataMem_Ready=1 completes the access: capture DataMem_In. Go to HOLD if M_StallExt, else stay in IDLE.
    - DataMem_Ready=0 moves to BUSY.
  - BUSY
    - Keep the request stable, even if M_Kill rises; the memory cannot abort.
    - On DataMem_Ready: capture the data. Go to HOLD if M_StallExt; otherwise go to IDLE.
    - If killed, discard the result. M_ReadData is don't-care.
  - HOLD
    - Drive no request. M_ReadData comes from the capture register.
    - Leave to IDLE when M_StallExt=0; the instruction advances that edge.
- M_Stall = (IDLE & valid op & ~Ready) | (BUSY & ~Ready).
- M_ReadData: formatted from DataMem_In in the completing cycle, from the capture register in HOLD.
- Zero-latency hit: one cycle, no stall.
- Back-to-back ops are allowed: each IDLE cycle with a valid op is a new access.

Optional Feature:
- Macro: DMEM_LLSC_EN.
- Defined: add a link-valid bit and a link address (addr[31:2]); both reset to 0.
  - A completed LL sets the link bit and stores the address.
  - SC writes only if the link is valid and the address matches. M_ReadData=1 on a successful SC.
  - A failing SC issues no request, raises no stall, and returns M_ReadData=0.
  - Any completed SC clears the link; any completed store to the linked word clears it.
- Undefined: M_LLSC is ignored. LL behaves as LW; SC behaves as SW and returns M_ReadData=1.

Test Plan:
- LB at addr 0x1003, big-endian, DataMem_In=0x11223380, sign-extend, Ready same cycle -> M_ReadData=0xFFFFFF80, M_Stall=0, DataMem_Address=0x400.
- SH at addr 0x2002, M_ReverseEndian=1, rd2=0x0000BEEF -> DataMem_Write=4'b1100, DataMem_Out=0xBEEFBEEF.
- LW at addr 0x11, Ready held 0 -> EXC_AdEL=1, DataMem_Read=0, M_Stall=0.
- LW with Ready low for 3 cycles -> M_Stall=1 for exactly 3 cycles; request and address stable; result valid in the 4th cycle.
- LW completes with M_StallExt=1 for 2 cycles -> one memory request only; M_ReadData holds the captured word through HOLD.
- DMEM_LLSC_EN: LL 0x40, then SC 0x40 -> write issued, M_ReadData=1. Second SC 0x40 -> no write, M_ReadData=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller: alignment checks, lane steering, load formatting and wait-state handshake.
// Optional LL/SC link tracking is enabled by defining DMEM_LLSC_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              M_MemByte,
  input  logic              M_MemHalf,
  input  logic              M_MemSignExtend,
  input  logic              M_ReverseEndian,
  input  logic              M_LLSC,
  input  logic              M_Kill,
  input  logic              M_StallExt,
  input  logic [31:0]       M_ALU_Result,
  input  logic [31:0]       M_ReadData2,
  input  logic              DataMem_Ready,
  input  logic [31:0]       DataMem_In,
  output logic [ADDR_W-1:0] DataMem_Address,
  output logic              DataMem_Read,
  output logic [3:0]        DataMem_Write,
  output logic [31:0]       DataMem_Out,
  output logic [31:0]       M_ReadData,
  output logic              M_Stall,
  output logic              EXC_AdEL,
  output logic              EXC_AdES
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e            state_q, state_d;
  logic [31:0]       capture_q, capture_d;
  logic [ADDR_W-1:0] busyAddr_q, busyAddr_d;
  logic              busyRead_q, busyRead_d;
  logic [3:0]        busyWe_q, busyWe_d;
  logic [31:0]       busyData_q, busyData_d;
  logic              killed_q, killed_d;
`ifdef DMEM_LLSC_EN
  logic              linkValid_q, linkValid_d;
  logic [29:0]       linkAddr_q, linkAddr_d;
`endif

  logic              isByte, isHalf, isWord, misaligned, anyOp, scOk, validOp;
  logic              complete, killedNow, goodComplete;
  logic [1:0]        off;
  logic [3:0]        weComb;
  logic [31:0]       wdataComb, shifted, loadFmt, result;
  logic [15:0]       halfSel;
  logic [ADDR_W-1:0] wordAddr;

  always_comb begin
    isByte     = M_MemByte;
    isHalf     = ~M_MemByte & M_MemHalf;
    isWord     = ~M_MemByte & ~M_MemHalf;
    off        = M_ALU_Result[1:0] ^ {2{M_ReverseEndian}};
    misaligned = (isHalf & M_ALU_Result[0]) | (isWord & (M_ALU_Result[1:0] != 2'b00));
    anyOp      = M_MemRead | M_MemWrite;
    wordAddr   = M_ALU_Result[ADDR_W+1:2];
`ifdef DMEM_LLSC_EN
    scOk       = linkValid_q & (linkAddr_q == M_ALU_Result[31:2]);
`else
    scOk       = 1'b1;
`endif
    // A failing SC is treated like no access at all: no request, no stall.
    validOp    = anyOp & ~misaligned & ~M_Kill & ~(M_MemWrite & M_LLSC & ~scOk);

    if (isByte) begin
      weComb    = 4'b0001 << ~off;
      wdataComb = {4{M_ReadData2[7:0]}};
    end else if (isHalf) begin
      weComb    = off[1] ? 4'b0011 : 4'b1100;
      wdataComb = {2{M_ReadData2[15:0]}};
    end else begin
      weComb    = 4'b1111;
      wdataComb = M_ReadData2;
    end

    shifted = DataMem_In >> {~off, 3'b000};
    halfSel = off[1] ? DataMem_In[15:0] : DataMem_In[31:16];
    if (isByte)
      loadFmt = {{24{M_MemSignExtend & shifted[7]}}, shifted[7:0]};
    else if (isHalf)
      loadFmt = {{16{M_MemSignExtend & halfSel[15]}}, halfSel};
    else
      loadFmt = DataMem_In;

    result = (M_MemWrite & M_LLSC) ? {31'b0, scOk} : loadFmt;
  end

  always_comb begin
    state_d      = state_q;
    capture_d    = capture_q;
    busyAddr_d   = busyAddr_q;
    busyRead_d   = busyRead_q;
    busyWe_d     = busyWe_q;
    busyData_d   = busyData_q;
    killed_d     = killed_q;
    complete     = 1'b0;
    killedNow    = 1'b0;
    case (state_q)
      IDLE: begin
        if (validOp) begin
          busyAddr_d = wordAddr;
          busyRead_d = M_MemRead;
          busyWe_d   = M_MemWrite ? weComb : 4'b0000;
          busyData_d = wdataComb;
          killed_d   = 1'b0;
          if (DataMem_Ready) begin
            complete  = 1'b1;
            capture_d = result;
            state_d   = M_StallExt ? HOLD : IDLE;
          end else begin
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // The memory cannot abort, so a late kill only discards the result.
        killedNow = killed_q | M_Kill;
        killed_d  = killedNow;
        if (DataMem_Ready) begin
          complete = 1'b1;
          if (killedNow) begin
            state_d = IDLE;
          end else begin
            capture_d = result;
            state_d   = M_StallExt ? HOLD : IDLE;
          end
        end
      end
      HOLD: begin
        if (!M_StallExt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    goodComplete = complete & ~killedNow;
  end

`ifdef DMEM_LLSC_EN
  always_comb begin
    linkValid_d = linkValid_q;
    linkAddr_d  = linkAddr_q;
    if (goodComplete) begin
      if (M_MemRead & M_LLSC) begin
        linkValid_d = 1'b1;
        linkAddr_d  = M_ALU_Result[31:2];
      end else if (M_MemWrite & (M_LLSC | (M_ALU_Result[31:2] == linkAddr_q))) begin
        linkValid_d = 1'b0;
      end
    end
  end
`endif

  always_comb begin
    DataMem_Address = '0;
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'b0000;
    DataMem_Out     = 32'h0;
    M_Stall         = 1'b0;
    M_ReadData      = 32'h0;
    EXC_AdEL        = 1'b0;
    EXC_AdES        = 1'b0;
    if (!reset) begin
      EXC_AdEL = M_MemRead & misaligned;
      EXC_AdES = M_MemWrite & misaligned;
      case (state_q)
        IDLE: begin
          if (validOp) begin
            DataMem_Address = wordAddr;
            DataMem_Read    = M_MemRead;
            DataMem_Write   = M_MemWrite ? weComb : 4'b0000;
            DataMem_Out     = wdataComb;
            M_Stall         = ~DataMem_Ready;
          end
          M_ReadData = result;
        end
        BUSY: begin
          DataMem_Address = busyAddr_q;
          DataMem_Read    = busyRead_q;
          DataMem_Write   = busyWe_q;
          DataMem_Out     = busyData_q;
          M_Stall         = ~DataMem_Ready;
          M_ReadData      = result;
        end
        HOLD:    M_ReadData = capture_q;
        default: M_ReadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      capture_q   <= 32'h0;
      busyAddr_q  <= '0;
      busyRead_q  <= 1'b0;
      busyWe_q    <= 4'b0000;
      busyData_q  <= 32'h0;
      killed_q    <= 1'b0;
`ifdef DMEM_LLSC_EN
      linkValid_q <= 1'b0;
      linkAddr_q  <= 30'h0;
`endif
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      busyAddr_q  <= busyAddr_d;
      busyRead_q  <= busyRead_d;
      busyWe_q    <= busyWe_d;
      busyData_q  <= busyData_d;
      killed_q    <= killed_d;
`ifdef DMEM_LLSC_EN
      linkValid_q <= linkValid_d;
      linkAddr_q  <= linkAddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: lane steering, load formatting, alignment traps, wait states, HOLD, kill, reset and LL/SC.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
  logic        M_ReverseEndian, M_LLSC, M_Kill, M_StallExt;
  logic [31:0] M_ALU_Result, M_ReadData2;
  logic        DataMem_Ready;
  logic [31:0] DataMem_In;
  logic [29:0] DataMem_Address;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [31:0] DataMem_Out;
  logic [31:0] M_ReadData;
  logic        M_Stall, EXC_AdEL, EXC_AdES;

  int errors = 0;
  int checks = 0;

  dmem_access_ctrl #(.ADDR_W(30)) dut (
    .clock(clock), .reset(reset),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte), .M_MemHalf(M_MemHalf),
    .M_MemSignExtend(M_MemSignExtend), .M_ReverseEndian(M_ReverseEndian), .M_LLSC(M_LLSC),
    .M_Kill(M_Kill), .M_StallExt(M_StallExt), .M_ALU_Result(M_ALU_Result), .M_ReadData2(M_ReadData2),
    .DataMem_Ready(DataMem_Ready), .DataMem_In(DataMem_In),
    .DataMem_Address(DataMem_Address), .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Out(DataMem_Out), .M_ReadData(M_ReadData), .M_Stall(M_Stall),
    .EXC_AdEL(EXC_AdEL), .EXC_AdES(EXC_AdES)
  );

  always #5 clock = ~clock;

  // One call = one cycle: inputs change on the falling edge, outputs are sampled 2ns later.
  task automatic applyStimulus(input logic rd, input logic wr, input logic byt, input logic half,
                               input logic sext, input logic rev, input logic llsc, input logic kill,
                               input logic stallExt, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rdy, input logic [31:0] din);
    @(negedge clock);
    M_MemRead = rd;  M_MemWrite = wr;  M_MemByte = byt;  M_MemHalf = half;
    M_MemSignExtend = sext;  M_ReverseEndian = rev;  M_LLSC = llsc;  M_Kill = kill;
    M_StallExt = stallExt;  M_ALU_Result = addr;  M_ReadData2 = wdata;
    DataMem_Ready = rdy;  DataMem_In = din;
    #2;
  endtask

  task automatic applyIdle();
    applyStimulus(0,0,0,0,0,0,0,0,0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h40, 32'h0, 1'b0, 32'hDEAD0000);
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL rst_read: got %b want 0", DataMem_Read); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", M_Stall); end
    checks++; if (DataMem_Address !== 30'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h want 0", DataMem_Address); end
    checks++; if (M_ReadData !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 0", M_ReadData); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h11, 32'h0, 1'b0, 32'h0);
    checks++; if (EXC_AdEL !== 1'b0) begin errors++; $display("[TB] FAIL rst_adel: got %b want 0", EXC_AdEL); end
    reset = 1'b0;
    applyIdle();
  endtask

  task automatic test_loads();
    applyStimulus(1,0,1,0,1,0,0,0,0, 32'h1003, 32'h0, 1'b1, 32'h11223380);
    checks++; if (M_ReadData !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_data: got %h want ffffff80", M_ReadData); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL lb_stall: got %b want 0", M_Stall); end
    checks++; if (DataMem_Address !== 30'h400) begin errors++; $display("[TB] FAIL lb_addr: got %h want 400", DataMem_Address); end
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL lb_read: got %b want 1", DataMem_Read); end
    applyStimulus(1,0,1,0,0,0,0,0,0, 32'h1003, 32'h0, 1'b1, 32'h11223380);
    checks++; if (M_ReadData !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_data: got %h want 00000080", M_ReadData); end
    applyStimulus(1,0,1,0,1,1,0,0,0, 32'h1003, 32'h0, 1'b1, 32'h11223380);
    checks++; if (M_ReadData !== 32'h00000011) begin errors++; $display("[TB] FAIL lb_rev_data: got %h want 00000011", M_ReadData); end
    applyStimulus(1,0,0,1,1,0,0,0,0, 32'h2, 32'h0, 1'b1, 32'h11228000);
    checks++; if (M_ReadData !== 32'hFFFF8000) begin errors++; $display("[TB] FAIL lh_data: got %h want ffff8000", M_ReadData); end
    applyStimulus(1,0,0,1,0,0,0,0,0, 32'h0, 32'h0, 1'b1, 32'h9ABC1234);
    checks++; if (M_ReadData !== 32'h00009ABC) begin errors++; $display("[TB] FAIL lhu_data: got %h want 00009abc", M_ReadData); end
  endtask

  task automatic test_stores();
    applyStimulus(0,1,0,1,0,1,0,0,0, 32'h2002, 32'h0000BEEF, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b1100) begin errors++; $display("[TB] FAIL sh_we: got %b want 1100", DataMem_Write); end
    checks++; if (DataMem_Out !== 32'hBEEFBEEF) begin errors++; $display("[TB] FAIL sh_data: got %h want beefbeef", DataMem_Out); end
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL sh_read: got %b want 0", DataMem_Read); end
    applyStimulus(0,1,1,0,0,0,0,0,0, 32'h3001, 32'h12345678, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b0100) begin errors++; $display("[TB] FAIL sb_we: got %b want 0100", DataMem_Write); end
    checks++; if (DataMem_Out !== 32'h78787878) begin errors++; $display("[TB] FAIL sb_data: got %h want 78787878", DataMem_Out); end
    applyStimulus(0,1,0,0,0,0,0,0,0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b1111) begin errors++; $display("[TB] FAIL sw_we: got %b want 1111", DataMem_Write); end
    checks++; if (DataMem_Out !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_data: got %h want deadbeef", DataMem_Out); end
    checks++; if (DataMem_Address !== 30'h4) begin errors++; $display("[TB] FAIL sw_addr: got %h want 4", DataMem_Address); end
  endtask

  task automatic test_misaligned();
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h11, 32'h0, 1'b0, 32'h0);
    checks++; if (EXC_AdEL !== 1'b1) begin errors++; $display("[TB] FAIL lw_adel: got %b want 1", EXC_AdEL); end
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_read: got %b want 0", DataMem_Read); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL lw_mis_stall: got %b want 0", M_Stall); end
    applyStimulus(0,1,0,1,0,0,0,0,0, 32'h2001, 32'h1234, 1'b0, 32'h0);
    checks++; if (EXC_AdES !== 1'b1) begin errors++; $display("[TB] FAIL sh_ades: got %b want 1", EXC_AdES); end
    checks++; if (DataMem_Write !== 4'b0000) begin errors++; $display("[TB] FAIL sh_mis_we: got %b want 0000", DataMem_Write); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL sh_mis_stall: got %b want 0", M_Stall); end
    applyStimulus(0,1,1,0,0,0,0,0,0, 32'h2003, 32'h000000AB, 1'b1, 32'h0);
    checks++; if (EXC_AdES !== 1'b0) begin errors++; $display("[TB] FAIL sb_odd_ades: got %b want 0", EXC_AdES); end
    checks++; if (DataMem_Write !== 4'b0001) begin errors++; $display("[TB] FAIL sb_odd_we: got %b want 0001", DataMem_Write); end
  endtask

  task automatic test_wait_states();
    int stallCnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1,0,0,0,0,0,0,0,0, 32'h20, 32'h0, 1'b0, 32'h0);
      if (M_Stall === 1'b1) stallCnt++;
      checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL wait_read[%0d]: got %b want 1", i, DataMem_Read); end
      checks++; if (DataMem_Address !== 30'h8) begin errors++; $display("[TB] FAIL wait_addr[%0d]: got %h want 8", i, DataMem_Address); end
    end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D);
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL wait_done_stall: got %b want 0", M_Stall); end
    checks++; if (M_ReadData !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL wait_data: got %h want cafef00d", M_ReadData); end
    checks++; if (stallCnt !== 3) begin errors++; $display("[TB] FAIL wait_stall_cycles: got %0d want 3", stallCnt); end
    applyIdle();
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL wait_after_read: got %b want 0", DataMem_Read); end
  endtask

  task automatic test_hold();
    int reqCount = 0;
    applyStimulus(1,0,0,0,0,0,0,0,1, 32'h30, 32'h0, 1'b1, 32'hA5A50001);
    reqCount += int'(DataMem_Read);
    checks++; if (M_ReadData !== 32'hA5A50001) begin errors++; $display("[TB] FAIL hold_c1_data: got %h want a5a50001", M_ReadData); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_c1_stall: got %b want 0", M_Stall); end
    applyStimulus(1,0,0,0,0,0,0,0,1, 32'h30, 32'h0, 1'b1, 32'hFFFF0000);
    reqCount += int'(DataMem_Read);
    checks++; if (M_ReadData !== 32'hA5A50001) begin errors++; $display("[TB] FAIL hold_c2_data: got %h want a5a50001", M_ReadData); end
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL hold_c2_read: got %b want 0", DataMem_Read); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h30, 32'h0, 1'b1, 32'hFFFF0000);
    reqCount += int'(DataMem_Read);
    checks++; if (M_ReadData !== 32'hA5A50001) begin errors++; $display("[TB] FAIL hold_c3_data: got %h want a5a50001", M_ReadData); end
    checks++; if (reqCount !== 1) begin errors++; $display("[TB] FAIL hold_requests: got %0d want 1", reqCount); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h34, 32'h0, 1'b1, 32'h00000042);
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL hold_exit_read: got %b want 1", DataMem_Read); end
    checks++; if (M_ReadData !== 32'h00000042) begin errors++; $display("[TB] FAIL hold_exit_data: got %h want 00000042", M_ReadData); end
  endtask

  task automatic test_kill();
    applyStimulus(1,0,0,0,0,0,0,1,0, 32'h50, 32'h0, 1'b0, 32'h0);
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL kill_idle_read: got %b want 0", DataMem_Read); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL kill_idle_stall: got %b want 0", M_Stall); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h50, 32'h0, 1'b0, 32'h0);
    applyStimulus(1,0,0,0,0,0,0,1,0, 32'h50, 32'h0, 1'b0, 32'h0);
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL kill_busy_read: got %b want 1", DataMem_Read); end
    checks++; if (DataMem_Address !== 30'h14) begin errors++; $display("[TB] FAIL kill_busy_addr: got %h want 14", DataMem_Address); end
    checks++; if (M_Stall !== 1'b1) begin errors++; $display("[TB] FAIL kill_busy_stall: got %b want 1", M_Stall); end
    applyStimulus(1,0,0,0,0,0,0,1,1, 32'h50, 32'h0, 1'b1, 32'h0);
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL kill_done_stall: got %b want 0", M_Stall); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h60, 32'h0, 1'b1, 32'h00000077);
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL kill_next_read: got %b want 1", DataMem_Read); end
    checks++; if (DataMem_Address !== 30'h18) begin errors++; $display("[TB] FAIL kill_next_addr: got %h want 18", DataMem_Address); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h40, 32'h0, 1'b1, 32'h00000001);
    checks++; if (DataMem_Address !== 30'h10) begin errors++; $display("[TB] FAIL b2b_addr0: got %h want 10", DataMem_Address); end
    checks++; if (M_ReadData !== 32'h00000001) begin errors++; $display("[TB] FAIL b2b_data0: got %h want 00000001", M_ReadData); end
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h44, 32'h0, 1'b1, 32'h00000002);
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL b2b_read1: got %b want 1", DataMem_Read); end
    checks++; if (DataMem_Address !== 30'h11) begin errors++; $display("[TB] FAIL b2b_addr1: got %h want 11", DataMem_Address); end
    checks++; if (M_ReadData !== 32'h00000002) begin errors++; $display("[TB] FAIL b2b_data1: got %h want 00000002", M_ReadData); end
  endtask

  task automatic test_mid_reset();
    applyStimulus(1,0,0,0,0,0,0,0,0, 32'h80, 32'h0, 1'b0, 32'h0);
    checks++; if (M_Stall !== 1'b1) begin errors++; $display("[TB] FAIL mrst_stall: got %b want 1", M_Stall); end
    applyIdle();
    checks++; if (DataMem_Read !== 1'b1) begin errors++; $display("[TB] FAIL mrst_busy_read: got %b want 1", DataMem_Read); end
    reset = 1'b1;
    #1;
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL mrst_drop_read: got %b want 0", DataMem_Read); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL mrst_drop_stall: got %b want 0", M_Stall); end
    #1;
    reset = 1'b0;
    applyIdle();
    checks++; if (DataMem_Read !== 1'b0) begin errors++; $display("[TB] FAIL mrst_after_read: got %b want 0", DataMem_Read); end
  endtask

  task automatic test_llsc();
`ifdef DMEM_LLSC_EN
    applyStimulus(1,0,0,0,0,0,1,0,0, 32'h40, 32'h0, 1'b1, 32'h00001234);
    checks++; if (M_ReadData !== 32'h00001234) begin errors++; $display("[TB] FAIL ll_data: got %h want 00001234", M_ReadData); end
    applyStimulus(0,1,0,0,0,0,1,0,0, 32'h40, 32'h5, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b1111) begin errors++; $display("[TB] FAIL sc1_we: got %b want 1111", DataMem_Write); end
    checks++; if (M_ReadData !== 32'h1) begin errors++; $display("[TB] FAIL sc1_result: got %h want 1", M_ReadData); end
    applyStimulus(0,1,0,0,0,0,1,0,0, 32'h40, 32'h5, 1'b0, 32'h0);
    checks++; if (DataMem_Write !== 4'b0000) begin errors++; $display("[TB] FAIL sc2_we: got %b want 0000", DataMem_Write); end
    checks++; if (M_Stall !== 1'b0) begin errors++; $display("[TB] FAIL sc2_stall: got %b want 0", M_Stall); end
    checks++; if (M_ReadData !== 32'h0) begin errors++; $display("[TB] FAIL sc2_result: got %h want 0", M_ReadData); end
`else
    applyStimulus(0,1,0,0,0,0,1,0,0, 32'h40, 32'h5, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b1111) begin errors++; $display("[TB] FAIL sc1_we: got %b want 1111", DataMem_Write); end
    checks++; if (M_ReadData !== 32'h1) begin errors++; $display("[TB] FAIL sc1_result: got %h want 1", M_ReadData); end
    applyStimulus(0,1,0,0,0,0,1,0,0, 32'h40, 32'h5, 1'b1, 32'h0);
    checks++; if (DataMem_Write !== 4'b1111) begin errors++; $display("[TB] FAIL sc2_we: got %b want 1111", DataMem_Write); end
    checks++; if (M_ReadData !== 32'h1) begin errors++; $display("[TB] FAIL sc2_result: got %h want 1", M_ReadData); end
`endif
    applyIdle();
  endtask

  initial begin
    reset = 1'b1;
    M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0; M_MemSignExtend = 0;
    M_ReverseEndian = 0; M_LLSC = 0; M_Kill = 0; M_StallExt = 0;
    M_ALU_Result = 32'h0; M_ReadData2 = 32'h0; DataMem_Ready = 0; DataMem_In = 32'h0;
    $display("[TB] starting dmem_access_ctrl directed tests");
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_wait_states();
    test_hold();
    test_kill();
    test_back_to_back();
    test_mid_reset();
    test_llsc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
